// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input valid/ready stream mux, round-robin or forced select, registered output.
// Optional STREAM_MUX_SKID_EN adds a 1-entry skid register so in_ready no longer depends on out_ready.
module stream_mux_rr #(
    parameter int DATA_SIZE = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = $clog2(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_IN-1:0]           in_valid,
    input  logic [NUM_IN*DATA_SIZE-1:0] in_data,
    output logic [NUM_IN-1:0]           in_ready,
    input  logic                        force_en,
    input  logic [SEL_W-1:0]            force_sel,
    output logic                        out_valid,
    output logic [DATA_SIZE-1:0]        out_data,
    output logic [SEL_W-1:0]            out_sel,
    input  logic                        out_ready
);
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d, gnt_idx;
    logic                 gnt_vld, force_ok, rdy_en, load, accept, in_xfer;
    logic [DATA_SIZE-1:0] gnt_data;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]     out_sel_q, out_sel_d;

    assign load      = !out_valid_q || out_ready;
    assign force_ok  = 32'(force_sel) < NUM_IN;
    assign rdy_en    = force_en ? force_ok : gnt_vld;
    assign gnt_data  = in_data[int'(gnt_idx)*DATA_SIZE +: DATA_SIZE];
    assign in_xfer   = gnt_vld && accept && !reset;
    assign rr_ptr_d  = (in_xfer && !force_en) ? gnt_idx : rr_ptr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

    // Pick the candidate channel: forced index, or first valid after rr_ptr with wrap
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        if (force_en) begin
            gnt_idx = force_ok ? force_sel : '0;
            gnt_vld = force_ok && in_valid[gnt_idx];
        end else begin
            for (int k = 1; k <= NUM_IN; k++) begin
                if (!gnt_vld && in_valid[(int'(rr_ptr_q) + k) % NUM_IN]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'((int'(rr_ptr_q) + k) % NUM_IN);
                end
            end
        end
    end

    // Raise ready on the selected channel only; nothing is accepted while reset is high
    always_comb begin
        in_ready = '0;
        if (!reset && rdy_en) in_ready[gnt_idx] = accept;
    end

`ifdef STREAM_MUX_SKID_EN
    logic                 skid_full_q, skid_full_d;
    logic [DATA_SIZE-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0]     skid_sel_q, skid_sel_d;

    assign accept = !skid_full_q;

    // Skid entry drains first; a beat accepted during a stall parks in the skid register
    always_comb begin
        out_valid_d = load ? (skid_full_q || in_xfer) : 1'b1;
        out_data_d  = !load ? out_data_q : skid_full_q ? skid_data_q : in_xfer ? gnt_data : out_data_q;
        out_sel_d   = !load ? out_sel_q : skid_full_q ? skid_sel_q : in_xfer ? gnt_idx : out_sel_q;
        skid_full_d = load ? 1'b0 : (skid_full_q || in_xfer);
        skid_data_d = (!load && in_xfer) ? gnt_data : skid_data_q;
        skid_sel_d  = (!load && in_xfer) ? gnt_idx : skid_sel_q;
    end

    // Skid storage, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end
`else
    assign accept = load;

    // Load a new beat when the output is free or draining; otherwise hold
    always_comb begin
        out_valid_d = load ? in_xfer : out_valid_q;
        out_data_d  = in_xfer ? gnt_data : out_data_q;
        out_sel_d   = in_xfer ? gnt_idx : out_sel_q;
    end
`endif

    // Output register and round-robin pointer; rr_ptr resets so channel 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= SEL_W'(NUM_IN - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: randomized and directed checks of stream_mux_rr against a queue-based model.
module tb_stream_mux_rr;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid, in_ready;
    logic [N*DW-1:0] in_data;
    logic            force_en;
    logic [SW-1:0]   force_sel;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_sel;
    logic            out_ready;

    int checks = 0, errors = 0;
    int ptr, gnt;
    logic [DW-1:0] qd[$];
    int            qs[$];
    logic [DW-1:0] hold_d;
    logic [SW-1:0] hold_s;

    stream_mux_rr #(.DATA_SIZE(DW), .NUM_IN(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .force_en(force_en), .force_sel(force_sel), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic fe, input logic [SW-1:0] fs, input logic ordy);
        in_valid  = v;
        force_en  = fe;
        force_sel = fs;
        out_ready = ordy;
        for (int k = 0; k < N; k++) in_data[k*DW +: DW] = $urandom;
    endtask

    // Expected grant/ready from the arbitration rules; output compared with head of the beat queue
    task automatic eval();
        int g, rs;
        bit acc;
        logic [N-1:0] er;
        #1;
        g = -1;
        rs = -1;
        if (force_en) begin
            if (int'(force_sel) < N) begin
                rs = int'(force_sel);
                if (in_valid[rs]) g = rs;
            end
        end else begin
            for (int k = 1; k <= N; k++) if (g < 0 && in_valid[(ptr + k) % N]) g = (ptr + k) % N;
            rs = g;
        end
`ifdef STREAM_MUX_SKID_EN
        acc = qd.size() < 2;
`else
        acc = qd.size() == 0 || out_ready;
`endif
        acc = acc && !reset;
        er = '0;
        if (rs >= 0 && acc) er[rs] = 1'b1;
        gnt = (g >= 0 && acc) ? g : -1;
        check("in_ready", in_ready, er);
        check("out_valid", out_valid, qd.size() > 0);
        if (qd.size() > 0) begin
            check("out_data", out_data, qd[0]);
            check("out_sel", out_sel, qs[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (qd.size() > 0 && out_ready) begin
            void'(qd.pop_front());
            void'(qs.pop_front());
        end
        if (gnt >= 0) begin
            qd.push_back(in_data[gnt*DW +: DW]);
            qs.push_back(gnt);
            if (!force_en) ptr = gnt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        qd.delete();
        qs.delete();
        ptr = N - 1;
        gnt = -1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sel", out_sel, 0);
        check("rst_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ptr = N - 1;
        gnt = -1;
        drive('1, 1'b0, '0, 1'b1);
        do_reset();

        drive(4'b0100, 1'b0, '0, 1'b1);
        in_data[2*DW +: DW] = 32'hA5;
        eval();
        check("t1_ready", in_ready, 4'b0100);
        tick();
        drive('0, 1'b0, '0, 1'b1);
        eval();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'hA5);
        check("t1_sel", out_sel, 2);
        tick();

        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive('1, 1'b0, '0, 1'b1);
            eval();
            check("rr_order", gnt, i % N);
            tick();
        end

        for (int i = 0; i < 4; i++) begin
            drive('1, 1'b1, 2'd3, 1'b1);
            eval();
            check("force_gnt", gnt, 3);
            tick();
        end
        drive('1, 1'b0, '0, 1'b1);
        eval();
        check("force_resume", gnt, 0);
        tick();

        drive('1, 1'b0, '0, 1'b0);
        eval();
        tick();
        hold_d = out_data;
        hold_s = out_sel;
        for (int i = 0; i < 5; i++) begin
            drive('1, 1'b0, '0, 1'b0);
            eval();
            check("hold_data", out_data, hold_d);
            check("hold_sel", out_sel, hold_s);
            check("hold_ready", in_ready, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive('1, 1'b0, '0, 1'b1);
            eval();
            tick();
        end

        check("t5_pre_valid", out_valid, 1);
        do_reset();
        drive('1, 1'b0, '0, 1'b1);
        eval();
        check("post_rst_gnt", gnt, 0);
        tick();

`ifdef STREAM_MUX_SKID_EN
        drive(4'b0001, 1'b0, '0, 1'b1);
        eval();
        tick();
        drive(4'b0001, 1'b0, '0, 1'b0);
        eval();
        check("skid_extra", in_ready, 4'b0001);
        tick();
        drive(4'b0001, 1'b0, '0, 1'b0);
        eval();
        check("skid_full", in_ready, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive('0, 1'b0, '0, 1'b1);
            eval();
            tick();
        end
`endif

        for (int i = 0; i < 400; i++) begin
            drive(N'($urandom), ($urandom % 4) == 0, SW'($urandom), ($urandom % 4) != 0);
            eval();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
